// File: rtl/axi_channel_perf_monitor.sv
// Passive per-channel valid/ready monitor: transfer/stall/burst/max-stall counters plus sticky protocol errors.
// Readout and err_any are registered with 1-cycle latency. The monitor never drives or backpressures the bus.
module axi_channel_perf_monitor #(
  parameter int NUM_CH        = 4,
  parameter int PAYLOAD_WIDTH = 64,
  parameter int CNT_WIDTH     = 32,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_CH-1:0]                         ch_valid,
  input  logic [NUM_CH-1:0]                         ch_ready,
  input  logic [NUM_CH-1:0]                         ch_last,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0]           ch_payload,
  input  logic                                      clear,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
  output logic [CNT_WIDTH-1:0]                      rd_xfer_cnt,
  output logic [CNT_WIDTH-1:0]                      rd_stall_cnt,
  output logic [CNT_WIDTH-1:0]                      rd_burst_cnt,
  output logic [CNT_WIDTH-1:0]                      rd_max_stall,
  output logic [2:0]                                rd_err,
  output logic                                      err_any
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // err = {timeout, payload_change, valid_drop}
  typedef struct packed {
    cnt_t       xfer;
    cnt_t       stall;
    cnt_t       burst;
    cnt_t       max_stall;
    logic [2:0] err;
  } ch_stat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH:0] TIMEOUT_EXT = (CNT_WIDTH + 1)'(STALL_TIMEOUT);

  function automatic cnt_t sat_inc(input cnt_t x);
    return (&x) ? x : x + CNT_WIDTH'(1);
  endfunction

  ch_stat_t stat_all [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                   state_q, state_d;
    ch_stat_t                 st_q, st_d;
    cnt_t                     run_q, run_d, run_inc;
    logic [PAYLOAD_WIDTH-1:0] cap_q, cap_d, pay;
    logic                     v, r, l;

    assign v   = ch_valid[i];
    assign r   = ch_ready[i];
    assign l   = ch_last[i];
    assign pay = ch_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign run_inc = sat_inc(run_q);

    always_comb begin
      state_d = state_q;
      st_d    = st_q;
      run_d   = run_q;
      cap_d   = cap_q;

      if (v && r) begin
        st_d.xfer = sat_inc(st_q.xfer);
        if (l) st_d.burst = sat_inc(st_q.burst);
      end
      if (v && !r) st_d.stall = sat_inc(st_q.stall);

      case (state_q)
        ST_IDLE: begin
          if (v && !r) begin
            state_d = ST_STALL;
            cap_d   = pay;
            run_d   = CNT_WIDTH'(1);
          end
        end
        ST_STALL: begin
          if (v && !r) begin
            run_d = run_inc;
            if (pay != cap_q) st_d.err[1] = 1'b1;
            if ({1'b0, run_inc} == TIMEOUT_EXT && run_inc != run_q) st_d.err[2] = 1'b1;
          end else begin
            // Leaving the stall, either by a transfer or by valid being withdrawn.
            state_d = ST_IDLE;
            run_d   = '0;
            if (run_q > st_q.max_stall) st_d.max_stall = run_q;
            if (!v) st_d.err[0] = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        state_q <= ST_IDLE;
        st_q    <= '0;
        run_q   <= '0;
        cap_q   <= '0;
      end else begin
        state_q <= state_d;
        st_q    <= st_d;
        run_q   <= run_d;
        cap_q   <= cap_d;
      end
    end

    assign stat_all[i] = st_q;
  end

  logic any_err;
  always_comb begin
    any_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) any_err = any_err | (|stat_all[i].err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_xfer_cnt  <= '0;
      rd_stall_cnt <= '0;
      rd_burst_cnt <= '0;
      rd_max_stall <= '0;
      rd_err       <= '0;
      err_any      <= 1'b0;
    end else begin
      if (32'(sel) < NUM_CH) begin
        rd_xfer_cnt  <= stat_all[sel].xfer;
        rd_stall_cnt <= stat_all[sel].stall;
        rd_burst_cnt <= stat_all[sel].burst;
        rd_max_stall <= stat_all[sel].max_stall;
        rd_err       <= stat_all[sel].err;
      end else begin
        rd_xfer_cnt  <= '0;
        rd_stall_cnt <= '0;
        rd_burst_cnt <= '0;
        rd_max_stall <= '0;
        rd_err       <= '0;
      end
      err_any <= any_err;
    end
  end

endmodule
